// File: rtl/demux_route_pkg.sv
// Shared definitions for the 1x8 demux packet router: channel count,
// select width and the sequencer state encoding.
package demux_route_pkg;

    localparam int NUM_CH = 8;
    localparam int SEL_W  = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_DROP  = 2'd2
    } state_t;

endpackage

// File: rtl/demux8_route_ctrl_demux1x8.sv
// Plain 1-to-8 demultiplexer: routes d to output i{s0,s1,s2}, with s0 as
// the most significant select bit. All other outputs are held low.
module demux1x8 (
    input  logic d,
    input  logic s0,
    input  logic s1,
    input  logic s2,
    output logic i0,
    output logic i1,
    output logic i2,
    output logic i3,
    output logic i4,
    output logic i5,
    output logic i6,
    output logic i7
);

    logic [2:0] idx;

    assign idx = {s0, s1, s2};
    assign i0  = d & (idx == 3'd0);
    assign i1  = d & (idx == 3'd1);
    assign i2  = d & (idx == 3'd2);
    assign i3  = d & (idx == 3'd3);
    assign i4  = d & (idx == 3'd4);
    assign i5  = d & (idx == 3'd5);
    assign i6  = d & (idx == 3'd6);
    assign i7  = d & (idx == 3'd7);

endmodule

// File: rtl/demux8_route_ctrl.sv
// Packet router/sequencer for the 1x8 demux datapath. Locks the channel
// select per packet, forwards beats through one output register with
// per-channel backpressure and drops packets aimed at disabled channels.
// Optional build macro DEMUX_PKT_CNT_EN adds 8-bit per-channel
// delivered-packet counters on pkt_cnt; without it pkt_cnt is tied to 0.
module demux8_route_ctrl #(
    parameter int DATA_W = 8,
    parameter int LEN_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [2:0]        in_dest,
    input  logic [LEN_W-1:0]  in_len,
    input  logic [7:0]        ch_en,
    output logic [7:0]        out_valid,
    input  logic [7:0]        out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [2:0]        sel,
    output logic              busy,
    output logic              drop_pulse,
    output logic [63:0]       pkt_cnt
);

    import demux_route_pkg::*;

    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

    state_t            state;
    state_t            state_next;
    logic              o_vld;
    logic [LEN_W-1:0]  remaining;
    logic [LEN_W-1:0]  remaining_next;
    logic              pipe_free;
    logic              accept;
    logic              load;
    logic              drop_next;

    // The output register can take a beat when empty or draining this cycle;
    // dropped beats never touch it, so DROP always accepts.
    assign pipe_free = ~o_vld | out_ready[sel];
    assign in_ready  = (state == ST_DROP) ? 1'b1 : pipe_free;
    assign accept    = in_valid & in_ready;
    assign busy      = (state != ST_IDLE);

    // Sequencer state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state, beat-count and load/drop decisions for the accepted beat
    always_comb begin
        state_next     = state;
        remaining_next = remaining;
        load           = 1'b0;
        drop_next      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    remaining_next = in_len;
                    if (ch_en[in_dest]) begin
                        load = 1'b1;
                        if (in_len != '0) begin
                            state_next = ST_BURST;
                        end
                    end else if (in_len != '0) begin
                        state_next = ST_DROP;
                    end else begin
                        drop_next = 1'b1;
                    end
                end
            end
            ST_BURST: begin
                if (accept) begin
                    load           = 1'b1;
                    remaining_next = remaining - LEN_ONE;
                    if (remaining == LEN_ONE) begin
                        state_next = ST_IDLE;
                    end
                end
            end
            ST_DROP: begin
                if (accept) begin
                    remaining_next = remaining - LEN_ONE;
                    if (remaining == LEN_ONE) begin
                        drop_next  = 1'b1;
                        state_next = ST_IDLE;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Output register: a load overrides a same-cycle drain so there is no bubble
    always_ff @(posedge clk) begin
        if (rst) begin
            o_vld      <= 1'b0;
            out_data   <= '0;
            sel        <= '0;
            remaining  <= '0;
            drop_pulse <= 1'b0;
        end else begin
            remaining  <= remaining_next;
            drop_pulse <= drop_next;
            if (load) begin
                o_vld    <= 1'b1;
                out_data <= in_data;
                if (state == ST_IDLE) begin
                    sel <= in_dest;
                end
            end else if (out_ready[sel]) begin
                o_vld <= 1'b0;
            end
        end
    end

    demux1x8 u_valid_decode (
        .d  (o_vld),
        .s0 (sel[2]),
        .s1 (sel[1]),
        .s2 (sel[0]),
        .i0 (out_valid[0]),
        .i1 (out_valid[1]),
        .i2 (out_valid[2]),
        .i3 (out_valid[3]),
        .i4 (out_valid[4]),
        .i5 (out_valid[5]),
        .i6 (out_valid[6]),
        .i7 (out_valid[7])
    );

`ifdef DEMUX_PKT_CNT_EN
    logic [7:0]       cnt [NUM_CH];
    logic             cnt_inc;
    logic [SEL_W-1:0] cnt_ch;

    // A delivered packet completes when a loaded beat also returns to IDLE
    always_comb begin
        cnt_inc = 1'b0;
        cnt_ch  = sel;
        if (load && (state_next == ST_IDLE)) begin
            cnt_inc = 1'b1;
            cnt_ch  = (state == ST_IDLE) ? in_dest : sel;
        end
    end

    // Per-channel wrapping packet counters
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt[i] <= '0;
            end
        end else if (cnt_inc) begin
            cnt[cnt_ch] <= cnt[cnt_ch] + 8'd1;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_cnt_out
        assign pkt_cnt[8*g +: 8] = cnt[g];
    end
`else
    assign pkt_cnt = '0;
`endif

endmodule

// File: tb/tb_demux8_route_ctrl.sv
// Self-checking bench for demux8_route_ctrl: packet-level reference model
// compared every cycle, plus literal spot checks of key cycles.
module tb_demux8_route_ctrl;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic [2:0]  in_dest;
    logic [3:0]  in_len;
    logic [7:0]  ch_en;
    logic [7:0]  out_valid;
    logic [7:0]  out_ready;
    logic [7:0]  out_data;
    logic [2:0]  sel;
    logic        busy;
    logic        drop_pulse;
    logic [63:0] pkt_cnt;

    int checks = 0;
    int errors = 0;
    bit chk_on = 0;

    demux8_route_ctrl #(.DATA_W(8), .LEN_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_dest    (in_dest),
        .in_len     (in_len),
        .ch_en      (ch_en),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .sel        (sel),
        .busy       (busy),
        .drop_pulse (drop_pulse),
        .pkt_cnt    (pkt_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: held output beat plus beats left in the current packet
    logic       m_vld;
    logic [7:0] m_data;
    logic [2:0] m_ch;
    logic [2:0] m_pch;
    int         m_left;
    bit         m_drop;
    logic       m_dpulse;
    logic [7:0] m_cnt [8];
    logic       m_rdy;
    logic [63:0] m_pkt;

    assign m_rdy = (m_left != 0 && m_drop) ? 1'b1 : (!m_vld || out_ready[m_ch]);

    always @(posedge clk) begin
        bit acc;
        bit drained;
        if (rst) begin
            m_vld = 0; m_data = 0; m_ch = 0; m_pch = 0;
            m_left = 0; m_drop = 0; m_dpulse = 0;
            for (int i = 0; i < 8; i++) m_cnt[i] = 0;
        end else begin
            acc     = in_valid && m_rdy;
            drained = m_vld && out_ready[m_ch];
            m_dpulse = 0;
            if (acc && m_left == 0) begin
                m_left = int'(in_len) + 1;
                m_drop = !ch_en[in_dest];
                m_pch  = in_dest;
            end
            if (acc) m_left = m_left - 1;
            if (acc && !m_drop) begin
                m_vld  = 1;
                m_data = in_data;
                m_ch   = m_pch;
                if (m_left == 0) m_cnt[m_pch] = m_cnt[m_pch] + 8'd1;
            end else if (drained) begin
                m_vld = 0;
            end
            if (acc && m_drop && m_left == 0) m_dpulse = 1;
        end
    end

    always_comb begin
        m_pkt = '0;
`ifdef DEMUX_PKT_CNT_EN
        for (int i = 0; i < 8; i++) m_pkt[8*i +: 8] = m_cnt[i];
`endif
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model, sampled on the falling edge
    always @(negedge clk) begin
        if (chk_on) begin
            checkOutput("m_in_ready",   64'(in_ready),   64'(m_rdy));
            checkOutput("m_out_valid",  64'(out_valid),  m_vld ? 64'(8'd1 << m_ch) : 64'd0);
            checkOutput("m_busy",       64'(busy),       64'(m_left != 0));
            checkOutput("m_drop_pulse", 64'(drop_pulse), 64'(m_dpulse));
            checkOutput("m_sel",        64'(sel),        64'(m_ch));
            checkOutput("m_pkt_cnt",    pkt_cnt,         m_pkt);
            if (m_vld) checkOutput("m_out_data", 64'(out_data), 64'(m_data));
        end
    end

    // One clock cycle of inputs; rdy_seen is in_ready just before the edge
    task automatic applyStimulus(input logic v, input logic [7:0] d, input logic [2:0] dest,
                                 input logic [3:0] len, input logic [7:0] en,
                                 input logic [7:0] rdy, output logic rdy_seen);
        in_valid  = v;
        in_data   = d;
        in_dest   = dest;
        in_len    = len;
        ch_en     = en;
        out_ready = rdy;
        @(negedge clk);
        rdy_seen = in_ready;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        logic r;
        rst = 1; in_valid = 0; in_data = 0; in_dest = 0; in_len = 0;
        ch_en = 8'hFF; out_ready = 8'hFF;
        repeat (2) @(posedge clk);
        #1;
        chk_on = 1;
        checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_out_data",  64'(out_data),  64'd0);
        checkOutput("rst_busy",      64'(busy),      64'd0);
        checkOutput("rst_pkt_cnt",   pkt_cnt,        64'd0);
        rst = 0;

        // T1 single beat
        applyStimulus(1, 8'hA5, 3'd5, 4'd0, 8'hFF, 8'hFF, r);
        checkOutput("t1_out_valid", 64'(out_valid), 64'h20);
        checkOutput("t1_out_data",  64'(out_data),  64'hA5);
        checkOutput("t1_busy",      64'(busy),      64'd0);
`ifdef DEMUX_PKT_CNT_EN
        checkOutput("t1_pkt_cnt",   pkt_cnt,        64'h0000_0100_0000_0000);
`else
        checkOutput("t1_pkt_cnt",   pkt_cnt,        64'd0);
`endif
        applyStimulus(0, 8'h00, 3'd0, 4'd0, 8'hFF, 8'hFF, r);
        checkOutput("t1_drained", 64'(out_valid), 64'd0);

        // T2 burst of 4
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 8'(8'h10 + i), 3'd2, 4'd3, 8'hFF, 8'hFF, r);
            checkOutput("t2_out_valid", 64'(out_valid), 64'h04);
            checkOutput("t2_out_data",  64'(out_data),  64'(8'h10 + i));
            checkOutput("t2_busy",      64'(busy),      (i < 3) ? 64'd1 : 64'd0);
        end
        applyStimulus(0, 8'h00, 3'd0, 4'd0, 8'hFF, 8'hFF, r);

        // T3 backpressure on ch2 with ch6 toggling
        applyStimulus(1, 8'h10, 3'd2, 4'd3, 8'hFF, 8'hFF, r);
        applyStimulus(1, 8'h11, 3'd2, 4'd3, 8'hFF, 8'hFF, r);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 8'h12, 3'd2, 4'd3, 8'hFF, (i % 2 == 0) ? 8'hBB : 8'hFB, r);
            checkOutput("t3_in_ready", 64'(r),         64'd0);
            checkOutput("t3_hold",     64'(out_data),  64'h11);
            checkOutput("t3_valid",    64'(out_valid), 64'h04);
        end
        applyStimulus(1, 8'h12, 3'd2, 4'd3, 8'hFF, 8'hFF, r);
        checkOutput("t3_resume", 64'(out_data), 64'h12);
        applyStimulus(1, 8'h13, 3'd2, 4'd3, 8'hFF, 8'hFF, r);
        checkOutput("t3_last", 64'(out_data), 64'h13);
        applyStimulus(0, 8'h00, 3'd0, 4'd0, 8'hFF, 8'hFF, r);

        // T4 drop to disabled ch2
        applyStimulus(1, 8'h55, 3'd2, 4'd1, 8'hFB, 8'hFF, r);
        checkOutput("t4_valid1", 64'(out_valid),  64'd0);
        checkOutput("t4_busy1",  64'(busy),       64'd1);
        checkOutput("t4_pulse1", 64'(drop_pulse), 64'd0);
        applyStimulus(1, 8'h66, 3'd2, 4'd1, 8'hFB, 8'hFF, r);
        checkOutput("t4_valid2", 64'(out_valid),  64'd0);
        checkOutput("t4_pulse2", 64'(drop_pulse), 64'd1);
        checkOutput("t4_busy2",  64'(busy),       64'd0);
        applyStimulus(0, 8'h00, 3'd0, 4'd0, 8'hFF, 8'hFF, r);
        checkOutput("t4_pulse3", 64'(drop_pulse), 64'd0);

        // T5 back-to-back single beats to ch1 then ch7
        applyStimulus(1, 8'h31, 3'd1, 4'd0, 8'hFF, 8'hFF, r);
        checkOutput("t5_ch1", 64'(out_valid), 64'h02);
        applyStimulus(1, 8'h77, 3'd7, 4'd0, 8'hFF, 8'hFF, r);
        checkOutput("t5_ch7",   64'(out_valid), 64'h80);
        checkOutput("t5_data7", 64'(out_data),  64'h77);
        applyStimulus(0, 8'h00, 3'd0, 4'd0, 8'hFF, 8'hFF, r);

        // Maximum length packet: 16 beats to ch3, ch_en changes mid-packet
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1, 8'(8'hC0 + i), 3'd3, 4'hF, (i == 0) ? 8'hFF : 8'h00, 8'hFF, r);
            if (i == 14) checkOutput("max_busy15", 64'(busy), 64'd1);
        end
        checkOutput("max_busy16", 64'(busy),     64'd0);
        checkOutput("max_data",   64'(out_data), 64'hCF);
        applyStimulus(0, 8'h00, 3'd0, 4'd0, 8'hFF, 8'hFF, r);

        // T6 reset mid-burst, then a fresh packet to ch0
        applyStimulus(1, 8'h40, 3'd4, 4'd3, 8'hFF, 8'hFF, r);
        applyStimulus(1, 8'h41, 3'd4, 4'd3, 8'hFF, 8'hFF, r);
        rst = 1;
        applyStimulus(0, 8'h00, 3'd4, 4'd3, 8'hFF, 8'hFF, r);
        rst = 0;
        checkOutput("t6_valid", 64'(out_valid), 64'd0);
        checkOutput("t6_busy",  64'(busy),      64'd0);
        applyStimulus(1, 8'h5C, 3'd0, 4'd0, 8'hFF, 8'hFF, r);
        checkOutput("t6_ch0",  64'(out_valid), 64'h01);
        checkOutput("t6_data", 64'(out_data),  64'h5C);
        applyStimulus(0, 8'h00, 3'd0, 4'd0, 8'hFF, 8'hFF, r);

        chk_on = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
